// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG master: tracked TAP states and scan limits.
// Optional TDO capture is controlled by JTAG_MASTER_TDO_CAPTURE_EN.
package jtag_pkg;

    typedef enum logic [2:0] {
        TLR_SEQ,
        RTI,
        SEL_DR,
        SEL_IR,
        CAPTURE,
        SHIFT,
        EXIT1,
        UPDATE
    } tap_state_e;

    localparam int unsigned TLR_LEN = 5;
    localparam int unsigned MAX_LEN = 32;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: DIV system clocks per TCK half-period, TCK parked low when idle.
// rise_o/fall_o mark the CLK cycle whose closing edge toggles TCK.
module jtag_tck_gen #(
    parameter int unsigned DIV = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    output logic tck_o,
    output logic rise_o,
    output logic fall_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       tck_q, tck_d;
    logic       wrap;

    assign wrap   = run_i && (cnt_q == 8'(DIV - 1));
    assign rise_o = wrap && !tck_q;
    assign fall_o = wrap && tck_q;
    assign tck_o  = tck_q;

    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (!run_i) begin
            cnt_d = '0;
            tck_d = 1'b0;
        end else if (wrap) begin
            cnt_d = '0;
            tck_d = ~tck_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

endmodule

// File: rtl/jtag_master.sv
// JTAG master: TAP reset sequence, then IR/DR scans of 1..32 bits on command.
// Define JTAG_MASTER_TDO_CAPTURE_EN to return captured TDO bits in rsp_data.
module jtag_master
    import jtag_pkg::*;
#(
    parameter int unsigned DIV = 5
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_ir,
    input  logic [4:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        TCK,
    output logic        TMS,
    output logic        TDI,
    input  logic        TDO
);

    localparam logic [2:0] TLR_LAST = 3'(TLR_LEN);

    tap_state_e         state_q, state_d;
    logic [2:0]         tlr_q, tlr_d;
    logic [4:0]         bit_q, bit_d;
    logic [4:0]         len_q, len_d;
    logic               ir_q, ir_d;
    logic               scan_q, scan_d;
    logic               ready_q, ready_d;
    logic               rspv_q, rspv_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic [MAX_LEN-1:0] tx_q, tx_d;
    logic               rise, fall;

    jtag_tck_gen #(
        .DIV(DIV)
    ) u_tck (
        .clk_i (CLK),
        .rst_ni(RST_N),
        .run_i (~ready_q),
        .tck_o (TCK),
        .rise_o(rise),
        .fall_o(fall)
    );

`ifdef JTAG_MASTER_TDO_CAPTURE_EN
    logic [MAX_LEN-1:0] rx_q, rx_d;
    assign rsp_data = rx_q;
`else
    logic unused_tdo;
    assign unused_tdo = TDO;
    assign rsp_data   = '0;
`endif

    assign cmd_ready = ready_q;
    assign busy      = ~ready_q;
    assign rsp_valid = rspv_q;
    assign TMS       = tms_q;
    assign TDI       = tdi_q;

    // State advances on TCK rise; TMS/TDI for the next rise are set on TCK fall.
    always_comb begin
        state_d = state_q;
        tlr_d   = tlr_q;
        bit_d   = bit_q;
        len_d   = len_q;
        ir_d    = ir_q;
        scan_d  = scan_q;
        ready_d = ready_q;
        rspv_d  = 1'b0;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        tx_d    = tx_q;
`ifdef JTAG_MASTER_TDO_CAPTURE_EN
        rx_d    = rx_q;
`endif
        if (ready_q) begin
            if (cmd_valid) begin
                ready_d = 1'b0;
                ir_d    = cmd_ir;
                len_d   = cmd_len;
                tx_d    = cmd_data;
                bit_d   = '0;
                scan_d  = 1'b1;
                tms_d   = 1'b1;
                tdi_d   = 1'b0;
`ifdef JTAG_MASTER_TDO_CAPTURE_EN
                rx_d    = '0;
`endif
            end
        end else if (rise) begin
            unique case (state_q)
                TLR_SEQ: begin
                    if (tms_q) tlr_d = tlr_q + 3'd1;
                    else       state_d = RTI;
                end
                RTI:     if (tms_q) state_d = SEL_DR;
                SEL_DR:  state_d = tms_q ? SEL_IR : CAPTURE;
                SEL_IR:  state_d = CAPTURE;
                CAPTURE: state_d = tms_q ? EXIT1 : SHIFT;
                SHIFT: begin
`ifdef JTAG_MASTER_TDO_CAPTURE_EN
                    rx_d[bit_q] = TDO;
`endif
                    tx_d  = tx_q >> 1;
                    bit_d = bit_q + 5'd1;
                    if (tms_q) state_d = EXIT1;
                end
                EXIT1:   state_d = UPDATE;
                UPDATE:  state_d = tms_q ? SEL_DR : RTI;
            endcase
        end else if (fall) begin
            tms_d = 1'b0;
            tdi_d = 1'b0;
            unique case (state_q)
                TLR_SEQ: tms_d = (tlr_q < TLR_LAST);
                RTI: begin
                    ready_d = 1'b1;
                    rspv_d  = scan_q;
                end
                SEL_DR:  tms_d = ir_q;
                SEL_IR:  tms_d = 1'b0;
                CAPTURE: tms_d = 1'b0;
                SHIFT: begin
                    tms_d = (bit_q == len_q);
                    tdi_d = tx_q[0];
                end
                EXIT1:   tms_d = 1'b1;
                UPDATE:  tms_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= TLR_SEQ;
            tlr_q   <= '0;
            bit_q   <= '0;
            len_q   <= '0;
            ir_q    <= 1'b0;
            scan_q  <= 1'b0;
            ready_q <= 1'b0;
            rspv_q  <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            tx_q    <= '0;
`ifdef JTAG_MASTER_TDO_CAPTURE_EN
            rx_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            tlr_q   <= tlr_d;
            bit_q   <= bit_d;
            len_q   <= len_d;
            ir_q    <= ir_d;
            scan_q  <= scan_d;
            ready_q <= ready_d;
            rspv_q  <= rspv_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            tx_q    <= tx_d;
`ifdef JTAG_MASTER_TDO_CAPTURE_EN
            rx_q    <= rx_d;
`endif
        end
    end

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master against a behavioural 16-state TAP model.
// Expected rsp_data follows JTAG_MASTER_TDO_CAPTURE_EN.
`timescale 1ns/1ps
module tb_jtag_master;

    localparam int DIV = 5;
    localparam logic [31:0] IDCODE = 32'h0BA0_0477;

    localparam int T_TLR = 0, T_RTI = 1, T_SELDR = 2, T_CAPDR = 3;
    localparam int T_SHDR = 4, T_EX1DR = 5, T_PAUDR = 6, T_EX2DR = 7;
    localparam int T_UPDR = 8, T_SELIR = 9, T_CAPIR = 10, T_SHIR = 11;
    localparam int T_EX1IR = 12, T_PAUIR = 13, T_EX2IR = 14, T_UPIR = 15;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ir = 1'b0;
    logic [4:0]  cmd_len = '0;
    logic [31:0] cmd_data = '0;
    logic        cmd_ready, rsp_valid, busy;
    logic [31:0] rsp_data;
    logic        TCK, TMS, TDI, TDO;
    logic        tdo_m = 1'b0;
    logic        tdo_force = 1'b0;

    int errors = 0;
    int checks = 0;

    jtag_master #(.DIV(DIV)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_ir   (cmd_ir),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .busy     (busy),
        .TCK      (TCK),
        .TMS      (TMS),
        .TDI      (TDI),
        .TDO      (TDO)
    );

    always #5 CLK = ~CLK;

    assign TDO = tdo_force ? 1'b1 : tdo_m;

    // TAP model
    int          tap_s = T_TLR;
    logic [3:0]  ir_reg = 4'b1110;
    logic [3:0]  ir_sr = '0;
    logic [31:0] dr_sr = '0;

    function automatic int tap_next(input int s, input logic m);
        case (s)
            T_TLR:   return m ? T_TLR   : T_RTI;
            T_RTI:   return m ? T_SELDR : T_RTI;
            T_SELDR: return m ? T_SELIR : T_CAPDR;
            T_CAPDR: return m ? T_EX1DR : T_SHDR;
            T_SHDR:  return m ? T_EX1DR : T_SHDR;
            T_EX1DR: return m ? T_UPDR  : T_PAUDR;
            T_PAUDR: return m ? T_EX2DR : T_PAUDR;
            T_EX2DR: return m ? T_UPDR  : T_SHDR;
            T_UPDR:  return m ? T_SELDR : T_RTI;
            T_SELIR: return m ? T_TLR   : T_CAPIR;
            T_CAPIR: return m ? T_EX1IR : T_SHIR;
            T_SHIR:  return m ? T_EX1IR : T_SHIR;
            T_EX1IR: return m ? T_UPIR  : T_PAUIR;
            T_PAUIR: return m ? T_EX2IR : T_PAUIR;
            T_EX2IR: return m ? T_UPIR  : T_SHIR;
            T_UPIR:  return m ? T_SELDR : T_RTI;
            default: return T_TLR;
        endcase
    endfunction

    always @(posedge TCK) begin
        case (tap_s)
            T_TLR:   ir_reg <= 4'b1110;
            T_CAPDR: dr_sr  <= IDCODE;
            T_SHDR:  dr_sr  <= {TDI, dr_sr[31:1]};
            T_CAPIR: ir_sr  <= 4'b0001;
            T_SHIR:  ir_sr  <= {TDI, ir_sr[3:1]};
            T_UPIR:  ir_reg <= ir_sr;
            default: ;
        endcase
        tap_s <= tap_next(tap_s, TMS);
    end

    always @(negedge TCK)
        tdo_m <= (tap_s == T_SHDR) ? dr_sr[0] :
                 (tap_s == T_SHIR) ? ir_sr[0] : 1'b0;

    // Edge log: TMS/TDI at every TCK rise plus the CLK stamp of the rise
    logic tms_log [0:511];
    logic tdi_log [0:511];
    int   stamp   [0:511];
    int   edges = 0;
    int   cyc = 0;
    int   rsp_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

    always @(posedge TCK) begin
        if (edges < 512) begin
            tms_log[edges] <= TMS;
            tdi_log[edges] <= TDI;
            stamp[edges]   <= cyc;
        end
        edges <= edges + 1;
    end

    function automatic logic [63:0] tms_vec(input int b, input int n);
        logic [63:0] v = '0;
        for (int k = 0; k < n; k++) v[k] = tms_log[b + k];
        return v;
    endfunction

    function automatic logic [63:0] tdi_vec(input int b, input int n);
        logic [63:0] v = '0;
        for (int k = 0; k < n; k++) v[k] = tdi_log[b + k];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_ready"}, cmd_ready, 1);
    endtask

    task automatic issue(input string tag, input logic ir,
                         input logic [4:0] len, input logic [31:0] data,
                         output int b);
        wait_ready(tag);
        b        = edges;
        cmd_ir   = ir;
        cmd_len  = len;
        cmd_data = data;
        cmd_valid = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0;
        chk({tag, "_ready_drop"}, cmd_ready, 0);
    endtask

    task automatic wait_rsp(input string tag, output logic [31:0] r);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_rsp_valid"}, rsp_valid, 1);
        chk({tag, "_ready_with_rsp"}, cmd_ready, 1);
        chk({tag, "_tck_low"}, TCK, 0);
        r = rsp_data;
        @(negedge CLK);
        chk({tag, "_rsp_pulse"}, rsp_valid, 0);
    endtask

    logic [31:0] exp_ir, exp_dr, exp_one, exp_a5;
    logic [31:0] r;
    int b, b2, c0;

    initial begin
`ifdef JTAG_MASTER_TDO_CAPTURE_EN
        exp_ir  = 32'h1;
        exp_dr  = IDCODE;
        exp_one = 32'h1;
        exp_a5  = 32'h77;
`else
        exp_ir  = '0;
        exp_dr  = '0;
        exp_one = '0;
        exp_a5  = '0;
`endif
        repeat (3) @(negedge CLK);
        chk("rst_tck", TCK, 0);
        chk("rst_tms", TMS, 1);
        chk("rst_tdi", TDI, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_rspd", rsp_data, 0);

        b = edges;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("tlr_busy", busy, 1);
        wait_ready("tlr");
        chk("tlr_periods", edges - b, 6);
        chk("tlr_tms", tms_vec(b, 6), 64'b011111);
        chk("tck_period", stamp[b + 1] - stamp[b], 2 * DIV);
        chk("tlr_tck_low", TCK, 0);
        chk("tlr_tap_rti", tap_s, T_RTI);

        c0 = rsp_cnt;
        issue("ir", 1'b1, 5'd3, 32'h4, b);
        wait_rsp("ir", r);
        chk("ir_periods", edges - b, 10);
        chk("ir_tms", tms_vec(b, 10), 64'b0110000011);
        chk("ir_tdi", tdi_vec(b, 10), 64'b0001000000);
        chk("ir_model", ir_reg, 4'b0100);
        chk("ir_rsp", r, exp_ir);
        chk("ir_rsp_cnt", rsp_cnt - c0, 1);

        c0 = rsp_cnt;
        issue("dr32", 1'b0, 5'd31, 32'h0, b);
        wait_rsp("dr32", r);
        chk("dr32_periods", edges - b, 37);
        chk("dr32_tms", tms_vec(b, 37), (64'd1 << 35) | (64'd1 << 34) | 64'd1);
        chk("dr32_tdi", tdi_vec(b, 37), 0);
        chk("dr32_rsp", r, exp_dr);
        chk("dr32_rsp_cnt", rsp_cnt - c0, 1);

        tdo_force = 1'b1;
        issue("dr1", 1'b0, 5'd0, 32'h0, b);
        wait_rsp("dr1", r);
        tdo_force = 1'b0;
        chk("dr1_periods", edges - b, 6);
        chk("dr1_tms", tms_vec(b, 6), 64'b011001);
        chk("dr1_rsp", r, exp_one);

        c0 = rsp_cnt;
        issue("dr8", 1'b0, 5'd7, 32'hA5, b);
        repeat (20) @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_ir    = 1'b1;
        cmd_len   = 5'd31;
        repeat (5) @(negedge CLK);
        cmd_valid = 1'b0;
        wait_rsp("dr8", r);
        chk("dr8_periods", edges - b, 13);
        chk("dr8_tms", tms_vec(b, 13), (64'd1 << 11) | (64'd1 << 10) | 64'd1);
        chk("dr8_tdi", tdi_vec(b, 13), 64'hA5 << 3);
        chk("dr8_rsp", r, exp_a5);
        b2 = edges;
        repeat (100) @(negedge CLK);
        chk("busy_cmd_ignored", edges - b2, 0);
        chk("busy_cmd_rsp_cnt", rsp_cnt - c0, 1);
        chk("idle_ready", cmd_ready, 1);

        c0 = rsp_cnt;
        issue("abort", 1'b0, 5'd31, 32'hFFFF_FFFF, b);
        begin
            int n = 0;
            while (edges < b + 13 && n < 3000) begin
                @(negedge CLK);
                n++;
            end
        end
        chk("abort_reach_bit10", edges - b, 13);
        chk("abort_tap_shift", tap_s, T_SHDR);
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("abort_tms", TMS, 1);
        chk("abort_tck", TCK, 0);
        chk("abort_busy", busy, 1);
        chk("abort_rspd", rsp_data, 0);
        repeat (3) @(negedge CLK);
        chk("abort_tck_hold", TCK, 0);
        b2 = edges;
        RST_N = 1'b1;
        wait_ready("abort_tlr");
        chk("abort_no_rsp", rsp_cnt - c0, 0);
        chk("abort_tlr_periods", edges - b2, 6);
        chk("abort_tlr_tms", tms_vec(b2, 6), 64'b011111);
        chk("abort_tap_rti", tap_s, T_RTI);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
